// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow out bo.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks,
// with a start/busy/done handshake and a result held between operations.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             b_bit;

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d_bit),
    .bo (b_bit)
  );

  // FSM, shift registers and output registers; diff/bout change only on the
  // final RUN edge so no partial result is ever visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= b_bit;
          if (cnt == LAST) begin
            diff  <= {d_bit, res_sh[WIDTH-1:1]};
            bout  <= b_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a long
// randomized back-to-back run against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int testsRun;
  int testsFailed;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed arithmetic, result wrapped to WIDTH bits.
  function automatic void refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic bi, output logic [WIDTH-1:0] d, output logic bo);
    int r;
    r  = int'(x) - int'(y) - int'(bi);
    d  = r[WIDTH-1:0];
    bo = (r < 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full operation; poke > 0 fires an extra start (a=99, b=1) at that RUN cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tbin, input int poke);
    logic [WIDTH-1:0] prevDiff;
    logic             prevBout;
    logic [WIDTH-1:0] expDiff;
    logic             expBout;
    int               cyc;
    refModel(ta, tb, tbin, expDiff, expBout);
    @(negedge clk);
    a        = ta;
    b        = tb;
    bin      = tbin;
    start    = 1'b1;
    prevDiff = diff;
    prevBout = bout;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 40) begin
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("diff_hold", 32'(diff), 32'(prevDiff));
      checkOutput("bout_hold", 32'(bout), 32'(prevBout));
      if (cyc == poke) begin
        a     = 8'd99;
        b     = 8'd1;
        start = 1'b1;
      end else begin
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(cyc), 32'(WIDTH + 1));
    checkOutput("busy_done", 32'(busy), 32'd0);
    checkOutput("diff", 32'(diff), 32'(expDiff));
    checkOutput("bout", 32'(bout), 32'(expBout));
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("diff_kept", 32'(diff), 32'(expDiff));
  endtask

  initial begin
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             ebin;
    logic [WIDTH-1:0] expDiff;
    logic             expBout;
    int               doneSeen;

    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    applyStimulus(8'd200, 8'd55, 1'b0, 0);
    applyStimulus(8'd55, 8'd200, 1'b0, 0);
    applyStimulus(8'd0, 8'd0, 1'b1, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    applyStimulus(8'd10, 8'd3, 1'b0, 3);

    // Abort mid-RUN: zeroed outputs next cycle and no done pulse afterwards.
    @(negedge clk);
    a     = 8'd77;
    b     = 8'd12;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_bout", 32'(bout), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(8'd20, 8'd30, 1'b1, 0);

    // Back-to-back with start held: a new op is accepted every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      ea   = WIDTH'($urandom);
      eb   = WIDTH'($urandom);
      ebin = 1'($urandom);
      a    = ea;
      b    = eb;
      bin  = ebin;
      refModel(ea, eb, ebin, expDiff, expBout);
      for (int j = 1; j <= WIDTH + 1; j++) begin
        @(negedge clk);
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        bin = 1'($urandom);
        if (j <= WIDTH) checkOutput("b2b_busy", 32'(busy), 32'd1);
      end
      checkOutput("b2b_done", 32'(done), 32'd1);
      checkOutput("b2b_diff", 32'(diff), 32'(expDiff));
      checkOutput("b2b_bout", 32'(bout), 32'(expBout));
      @(negedge clk);
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
